// File: rtl/mrna_iso_pkg.sv
// Shared types and constants for the mRNA isolation sequencer: state encoding,
// per-state open-valve masks and the peristaltic pump phase table.
package mrna_iso_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CELLS   = 3'd1,
        ST_BEADS   = 3'd2,
        ST_LYSIS   = 3'd3,
        ST_MIX     = 3'd4,
        ST_WASH    = 3'd5,
        ST_COLLECT = 3'd6
    } state_t;

    // Bit order {cells_in, cells_out, beads, lysis_in, lysis_out, sieve, sep, push, waste}; 1 = open.
    localparam logic [8:0] OPEN_IDLE    = 9'b000000000;
    localparam logic [8:0] OPEN_CELLS   = 9'b110001000;
    localparam logic [8:0] OPEN_BEADS   = 9'b001001000;
    localparam logic [8:0] OPEN_LYSIS   = 9'b000110000;
    localparam logic [8:0] OPEN_MIX     = 9'b000000000;
    localparam logic [8:0] OPEN_WASH    = 9'b000001011;
    localparam logic [8:0] OPEN_COLLECT = 9'b000000110;

    // Entry [0] is the first phase driven on MIX entry; {pump3, pump2, pump1}.
    localparam logic [5:0][2:0] PUMP_SEQ = {3'b010, 3'b011, 3'b001, 3'b101, 3'b100, 3'b110};
    localparam logic [2:0]      PUMP_CLOSED = 3'b111;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [8:0] open_mask(input state_t s);
        case (s)
            ST_CELLS:   return OPEN_CELLS;
            ST_BEADS:   return OPEN_BEADS;
            ST_LYSIS:   return OPEN_LYSIS;
            ST_MIX:     return OPEN_MIX;
            ST_WASH:    return OPEN_WASH;
            ST_COLLECT: return OPEN_COLLECT;
            default:    return OPEN_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mrna_iso_pump_phaser.sv
// Three-pump peristaltic phase generator: steps one phase per tick through the
// six-entry phase table for a given number of full cycles; closed (111) when disabled.
module mrna_iso_pump_phaser
    import mrna_iso_pkg::*;
#(
    parameter int CYC_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             tick,
    input  logic [CYC_W-1:0] cycles,
    output logic [2:0]       pump,
    output logic             cycle_done
);

    logic             run_q, run_d;
    logic [2:0]       phase_q, phase_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [2:0]       pump_q, pump_d;
    logic             last_phase;

    assign last_phase = (phase_q == 3'd5);
    assign cycle_done = run_q && tick && last_phase && (cyc_q == cycles - CYC_W'(1));
    assign pump       = pump_q;

    // The tick that coincides with enabling is not a phase step: phase 0 is shown first.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        run_d   = run_q;
        phase_d = phase_q;
        cyc_d   = cyc_q;
        if (!en) begin
            run_d   = 1'b0;
            phase_d = '0;
            cyc_d   = '0;
        end else if (!run_q) begin
            run_d   = 1'b1;
            phase_d = '0;
            cyc_d   = '0;
        end else if (tick) begin
            if (!last_phase) begin
                phase_d = phase_q + 3'd1;
            end else begin
                phase_d = '0;
                cyc_d   = cycle_done ? '0 : cyc_q + CYC_W'(1);
            end
        end
        pump_d = run_d ? PUMP_SEQ[phase_d] : PUMP_CLOSED;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            run_q   <= 1'b0;
            phase_q <= '0;
            cyc_q   <= '0;
            pump_q  <= PUMP_CLOSED;
        end else begin
            run_q   <= run_d;
            phase_q <= phase_d;
            cyc_q   <= cyc_d;
            pump_q  <= pump_d;
        end
    end

endmodule

// File: rtl/mrna_iso_seq.sv
// Sequential valve/pump controller for an N_CH-channel mRNA isolation bank:
// CELLS -> BEADS -> LYSIS -> MIX -> WASH -> COLLECT, with abort to the all-closed safe state.
module mrna_iso_seq
    import mrna_iso_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int T_CELLS    = 8,
    parameter int T_BEADS    = 8,
    parameter int T_LYSIS    = 16,
    parameter int MIX_CYCLES = 4,
    parameter int T_WASH     = 8,
    parameter int T_COLLECT  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic            start,
    input  logic            abort,
    input  logic [N_CH-1:0] ch_mask,
    output logic            cells_in_ctrl,
    output logic            cells_out_ctrl,
    output logic            beads_ctrl,
    output logic            lysis_in_ctrl,
    output logic            lysis_out_ctrl,
    output logic            sieve_ctrl,
    output logic            sep_ctrl,
    output logic            push_ctrl,
    output logic            waste_ctrl,
    output logic [N_CH-1:0] collect_ctrl,
    output logic [2:0]      pump,
    output logic            busy,
    output logic            done,
    output logic            aborted,
    output logic [2:0]      state
);

    localparam int T_MAX = max_int(max_int(max_int(T_CELLS, T_BEADS), max_int(T_LYSIS, T_WASH)),
                                   T_COLLECT);
    localparam int CNT_W = $clog2(T_MAX + 1);
    localparam int CYC_W = $clog2(MIX_CYCLES + 1);

    function automatic logic [N_CH-1:0] low_bit(input logic [N_CH-1:0] m);
        return m & (~m + N_CH'(1));
    endfunction

    // Reset asserts asynchronously but releases two clocks later, aligned to clk.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, dwell_last;
    logic [N_CH-1:0]  mask_q, mask_d;
    logic             dwell_hit, mix_done, pump_en;
    logic [8:0]       valves_q, valves_d;
    logic [N_CH-1:0]  collect_q, collect_d;
    logic             busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_CELLS:   dwell_last = CNT_W'(T_CELLS - 1);
            ST_BEADS:   dwell_last = CNT_W'(T_BEADS - 1);
            ST_LYSIS:   dwell_last = CNT_W'(T_LYSIS - 1);
            ST_WASH:    dwell_last = CNT_W'(T_WASH - 1);
            ST_COLLECT: dwell_last = CNT_W'(T_COLLECT - 1);
            default:    dwell_last = '0;
        endcase
    end

    assign dwell_hit = tick && (cnt_q == dwell_last);

    // Abort outranks tick and start; the dwell counter clears on any state or channel change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && |ch_mask) begin
                        state_d = ST_CELLS;
                        mask_d  = ch_mask;
                        cnt_d   = '0;
                    end
                end
                ST_MIX: begin
                    if (mix_done) state_d = ST_WASH;
                end
                default: begin
                    if (dwell_hit) begin
                        cnt_d = '0;
                        case (state_q)
                            ST_CELLS: state_d = ST_BEADS;
                            ST_BEADS: state_d = ST_LYSIS;
                            ST_LYSIS: state_d = ST_MIX;
                            ST_WASH:  state_d = ST_COLLECT;
                            ST_COLLECT: begin
                                mask_d  = mask_q & ~low_bit(mask_q);
                                state_d = (mask_d == '0) ? ST_IDLE : ST_COLLECT;
                            end
                            default:  state_d = ST_IDLE;
                        endcase
                    end else if (tick) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Outputs are registered from the next state so valves move on the state-change edge.
    always_comb begin
        valves_d  = ~open_mask(state_d);
        collect_d = '1;
        if (state_d == ST_COLLECT) collect_d = ~low_bit(mask_d);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_q == ST_COLLECT) && (state_d == ST_IDLE) && !abort;
        aborted_d = (state_q != ST_IDLE) && abort;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            valves_q  <= '1;
            collect_q <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            valves_q  <= valves_d;
            collect_q <= collect_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign pump_en = (state_d == ST_MIX);

    mrna_iso_pump_phaser #(
        .CYC_W (CYC_W)
    ) u_pump (
        .clk        (clk),
        .rst_n      (rst_int_n),
        .en         (pump_en),
        .tick       (tick),
        .cycles     (CYC_W'(MIX_CYCLES)),
        .pump       (pump),
        .cycle_done (mix_done)
    );

    assign {cells_in_ctrl, cells_out_ctrl, beads_ctrl, lysis_in_ctrl, lysis_out_ctrl,
            sieve_ctrl, sep_ctrl, push_ctrl, waste_ctrl} = valves_q;
    assign collect_ctrl = collect_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign state        = state_q;

endmodule

// File: tb/tb_mrna_iso_seq.sv
// Directed bench for mrna_iso_seq with default parameters (N_CH = 4).
module tb_mrna_iso_seq;

    logic       clk = 1'b0;
    logic       rst_n, tick, start, abort;
    logic [3:0] ch_mask;
    logic       cells_in_ctrl, cells_out_ctrl, beads_ctrl, lysis_in_ctrl, lysis_out_ctrl;
    logic       sieve_ctrl, sep_ctrl, push_ctrl, waste_ctrl;
    logic [3:0] collect_ctrl;
    logic [2:0] pump;
    logic       busy, done, aborted;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;
    int tick_period = 1;
    int tick_cnt = 0;
    int n_done, n_busy, n_abort;

    logic [2:0] seq [6] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};

    mrna_iso_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tick           (tick),
        .start          (start),
        .abort          (abort),
        .ch_mask        (ch_mask),
        .cells_in_ctrl  (cells_in_ctrl),
        .cells_out_ctrl (cells_out_ctrl),
        .beads_ctrl     (beads_ctrl),
        .lysis_in_ctrl  (lysis_in_ctrl),
        .lysis_out_ctrl (lysis_out_ctrl),
        .sieve_ctrl     (sieve_ctrl),
        .sep_ctrl       (sep_ctrl),
        .push_ctrl      (push_ctrl),
        .waste_ctrl     (waste_ctrl),
        .collect_ctrl   (collect_ctrl),
        .pump           (pump),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .state          (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, required $finish before 2000000");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [8:0] valves();
        return {cells_in_ctrl, cells_out_ctrl, beads_ctrl, lysis_in_ctrl, lysis_out_ctrl,
                sieve_ctrl, sep_ctrl, push_ctrl, waste_ctrl};
    endfunction

    function automatic logic [15:0] outs();
        return {valves(), collect_ctrl, pump};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        tick_cnt = (tick_cnt + 1) % tick_period;
        tick = (tick_cnt == 0);
    endtask

    task automatic run_until(input logic [2:0] st, input int budget, input string tag);
        for (int i = 0; i < budget && state !== st; i++) cyc();
        check(tag, state, st);
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b1; start = 1'b0; abort = 1'b0; ch_mask = 4'b0000;
        repeat (3) cyc();
        check("reset_outs", outs(), 16'hFFFF);
        check("reset_flags", {busy, done, aborted}, 3'b000);
        check("reset_state", state, 3'd0);
        rst_n = 1'b1;
        repeat (3) cyc();
        check("post_reset_state", state, 3'd0);

        // Full protocol, tick every cycle, channels 0 and 2.
        ch_mask = 4'b0101; start = 1'b1;
        cyc();
        start = 1'b0;
        n_done = 0; n_busy = 0;
        for (int k = 1; k <= 80; k++) begin
            if (busy) n_busy++;
            if (done) n_done++;
            case (k)
                1:  begin check("cells_state", state, 3'd1);
                          check("cells_valves", valves(), 9'b001110111); end
                8:  check("cells_last", state, 3'd1);
                9:  begin check("beads_state", state, 3'd2);
                          check("beads_valves", valves(), 9'b110110111); end
                17: begin check("lysis_state", state, 3'd3);
                          check("lysis_valves", valves(), 9'b111001111); end
                33: begin check("mix_state", state, 3'd4);
                          check("mix_valves", valves(), 9'h1FF);
                          check("mix_pump_first", pump, 3'b110); end
                56: check("mix_pump_last", pump, 3'b010);
                57: begin check("wash_state", state, 3'd5);
                          check("wash_pump", pump, 3'b111);
                          check("wash_valves", valves(), 9'b111110100); end
                65: begin check("col0_first", collect_ctrl, 4'b1110);
                          check("col_valves", valves(), 9'b111111001); end
                68: check("col0_last", collect_ctrl, 4'b1110);
                69: check("col2_first", collect_ctrl, 4'b1011);
                72: begin check("col2_last", collect_ctrl, 4'b1011);
                          check("col2_busy", busy, 1'b1); end
                73: begin check("end_state", state, 3'd0);
                          check("done_pulse", done, 1'b1);
                          check("end_outs", outs(), 16'hFFFF); end
                74: check("done_cleared", done, 1'b0);
                default: ;
            endcase
            cyc();
        end
        check("done_count", n_done, 1);
        check("busy_cycles", n_busy, 72);

        // MIX pump sequence with a tick every third cycle.
        tick_period = 3; tick_cnt = 0; tick = 1'b1;
        ch_mask = 4'b0001; start = 1'b1;
        cyc();
        start = 1'b0;
        run_until(3'd4, 400, "reach_mix");
        for (int j = 0; j < 72; j++) begin
            check("mix_pump_seq", pump, seq[(j / 3) % 6]);
            cyc();
        end
        check("mix_exit_pump", pump, 3'b111);
        check("mix_exit_state", state, 3'd5);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("wash_abort_state", state, 3'd0);
        check("wash_abort_pulse", aborted, 1'b1);
        tick_period = 1; tick_cnt = 0; tick = 1'b1;
        cyc();
        check("wash_abort_clear", aborted, 1'b0);

        // Empty mask start and abort while idle are both ignored.
        ch_mask = 4'b0000; start = 1'b1; abort = 1'b1;
        cyc();
        start = 1'b0; abort = 1'b0;
        check("empty_start_state", state, 3'd0);
        check("empty_start_outs", outs(), 16'hFFFF);
        check("empty_start_flags", {busy, done, aborted}, 3'b000);

        // Abort on the fifth LYSIS tick, then a fresh start is accepted.
        ch_mask = 4'b0011; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (20) cyc();
        check("lysis_before_abort", state, 3'd3);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("lysis_abort_state", state, 3'd0);
        check("lysis_abort_outs", outs(), 16'hFFFF);
        check("lysis_abort_flags", {busy, done, aborted}, 3'b001);
        cyc();
        check("lysis_abort_once", {done, aborted}, 2'b00);

        // Restart on channel 1, then asynchronous reset mid-COLLECT.
        ch_mask = 4'b0010; start = 1'b1;
        cyc();
        start = 1'b0;
        check("restart_state", state, 3'd1);
        run_until(3'd6, 100, "reach_collect");
        check("col1_valve", collect_ctrl, 4'b1101);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", outs(), 16'hFFFF);
        check("async_rst_flags", {busy, done, aborted}, 3'b000);
        check("async_rst_state", state, 3'd0);
        cyc();
        rst_n = 1'b1;
        n_done = 0; n_abort = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) n_done++;
            if (aborted) n_abort++;
            cyc();
        end
        check("post_rst_no_pulse", n_done + n_abort, 0);
        check("post_rst_state", state, 3'd0);

        // Ignored start while busy; abort coinciding with a dwell-exit tick.
        ch_mask = 4'b0101; start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (2) cyc();
        ch_mask = 4'b1000; start = 1'b1;
        cyc();
        start = 1'b0;
        check("busy_start_ignored", state, 3'd1);
        repeat (4) cyc();
        check("cells_dwell_kept", state, 3'd1);
        cyc();
        check("cells_exit_on_time", state, 3'd2);
        repeat (56) cyc();
        check("latched_col_state", state, 3'd6);
        check("latched_mask_ch0", collect_ctrl, 4'b1110);
        repeat (3) cyc();
        check("col0_before_abort", collect_ctrl, 4'b1110);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_wins_state", state, 3'd0);
        check("abort_wins_flags", {busy, done, aborted}, 3'b001);
        check("abort_wins_outs", outs(), 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
